// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg
// Shared types and constants for the BCD stopwatch.
//   state_e   : run-control FSM states (IDLE, RUN, PAUSE)
//   MAX_UNITS : highest value of a decimal digit (9)
//   MAX_TENS  : highest value of the seconds-tens digit (5)
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_e;

   localparam logic [3:0] MAX_UNITS = 4'd9;
   localparam logic [3:0] MAX_TENS  = 4'd5;

endpackage

// File: rtl/bcd_digit.sv
// bcd_digit
// One BCD counter digit that counts 0..MAX and wraps to 0.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, q -> 0
//   clr   : synchronous clear, q -> 0, wins over inc
//   inc   : advance by one on this edge
//   q     : current digit value, always 0..MAX
//   carry : combinational, high when inc is applied to a digit at MAX,
//           i.e. this edge wraps the digit and must advance the next one
module bcd_digit
   import stopwatch_pkg::*;
#(
   parameter logic [3:0] MAX = MAX_UNITS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       inc,
   output logic [3:0] q,
   output logic       carry
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= 4'd0;
      end else if (clr) begin
         q <= 4'd0;
      end else if (inc) begin
         // >= rather than == so that q can never leave 0..MAX
         q <= (q >= MAX) ? 4'd0 : q + 4'd1;
      end
   end

   always_comb begin
      carry = inc && (q == MAX);
   end

endmodule

// File: rtl/bcd_stopwatch.sv
// bcd_stopwatch
// MM.hh-style stopwatch (seconds 00..59, hundredths 00..99) in BCD.
// Ports:
//   clk        : rising-edge system clock
//   rst_n      : asynchronous active-low reset
//   start_stop : debounced run/pause request, acts on its rising edge
//   clear      : level clear to IDLE / 00.00, highest priority
//   digit0..3  : hundredths, tenths, seconds units, seconds tens (BCD)
//   running    : high while the FSM is in RUN
//   wrap       : one-cycle pulse, high in the cycle the count shows 00.00
//                after rolling over from 59.99
// Parameters:
//   CLK_HZ / TICK_HZ set the prescaler length DIV (must be >= 2).
module bcd_stopwatch
   import stopwatch_pkg::*;
#(
   parameter int CLK_HZ  = 50_000_000,
   parameter int TICK_HZ = 100
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_stop,
   input  logic       clear,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic [3:0] digit3,
   output logic       running,
   output logic       wrap
);

   localparam int DIV = CLK_HZ / TICK_HZ;
   localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

   if (DIV < 2) begin : g_div_check
      $error("bcd_stopwatch: CLK_HZ/TICK_HZ must be at least 2");
   end

   state_e        state;
   state_e        state_nxt;
   logic          ss_q;
   logic          ss_edge;
   logic [PW-1:0] presc;
   logic          tick;
   logic          c0, c1, c2, c3;

   // Rising edge of start_stop; holding it high produces a single edge.
   always_comb begin
      ss_edge = start_stop && !ss_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_q <= 1'b0;
      end else begin
         ss_q <= start_stop;
      end
   end

   // ---------------- run-control FSM ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = IDLE;
      end else if (ss_edge) begin
         case (state)
            IDLE:    state_nxt = RUN;
            RUN:     state_nxt = PAUSE;
            PAUSE:   state_nxt = RUN;
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_comb begin
      running = (state == RUN);
   end

   // ---------------- prescaler ----------------
   // Tick is judged on the current state, so a tick coinciding with a
   // RUN->PAUSE edge is still consumed before the pause takes effect.
   always_comb begin
      tick = (state == RUN) && (presc == PRESC_LAST) && !clear;
   end

   // Held (not reset) in PAUSE so a resumed run finishes the partial tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc <= '0;
      end else if (clear) begin
         presc <= '0;
      end else begin
         case (state)
            RUN:     presc <= tick ? '0 : presc + 1'b1;
            PAUSE:   presc <= presc;
            default: presc <= '0;
         endcase
      end
   end

   // ---------------- BCD digit chain ----------------
   // Each digit's carry advances the next; the tens digit wraps 5->0 on
   // its own, so rollover to 00.00 needs no extra clear.
   bcd_digit #(.MAX(MAX_UNITS)) u_d0 (
      .clk(clk), .rst_n(rst_n), .clr(clear), .inc(tick), .q(digit0), .carry(c0)
   );
   bcd_digit #(.MAX(MAX_UNITS)) u_d1 (
      .clk(clk), .rst_n(rst_n), .clr(clear), .inc(c0), .q(digit1), .carry(c1)
   );
   bcd_digit #(.MAX(MAX_UNITS)) u_d2 (
      .clk(clk), .rst_n(rst_n), .clr(clear), .inc(c1), .q(digit2), .carry(c2)
   );
   bcd_digit #(.MAX(MAX_TENS)) u_d3 (
      .clk(clk), .rst_n(rst_n), .clr(clear), .inc(c2), .q(digit3), .carry(c3)
   );

   // Registered so the pulse lines up with the cycle showing 00.00.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrap <= 1'b0;
      end else begin
         wrap <= c3 && !clear;
      end
   end

endmodule

// File: tb/tb_bcd_stopwatch.sv
// tb_bcd_stopwatch
// Directed bench for bcd_stopwatch with DIV = 4 (CLK_HZ=400, TICK_HZ=100).
// All driving and sampling happens on the falling clock edge.
module tb_bcd_stopwatch;

   logic        clk;
   logic        rst_n;
   logic        start_stop;
   logic        clear;
   logic [3:0]  digit0, digit1, digit2, digit3;
   logic        running;
   logic        wrap;
   logic [15:0] digits;

   int pass_cnt  = 0;
   int total_cnt = 0;

   localparam int DIV = 4;

   bcd_stopwatch #(.CLK_HZ(400), .TICK_HZ(100)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start_stop(start_stop),
      .clear(clear),
      .digit0(digit0),
      .digit1(digit1),
      .digit2(digit2),
      .digit3(digit3),
      .running(running),
      .wrap(wrap)
   );

   assign digits = {digit3, digit2, digit1, digit0};

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- driver tasks ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1;
      cyc(1);
      start_stop = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      cyc(1);
      clear = 1'b0;
      cyc(1);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      start_stop = 1'b0;
      clear = 1'b0;
      #1;
      total_cnt++;
      if (digits !== 16'h0000) $display("FAIL reset_digits got %h want 0000", digits);
      else pass_cnt++;
      total_cnt++;
      if (running !== 1'b0 || wrap !== 1'b0)
         $display("FAIL reset_flags got running=%b wrap=%b want 0 0", running, wrap);
      else pass_cnt++;
      cyc(2);
      rst_n = 1'b1;
      cyc(5);
      total_cnt++;
      if (digits !== 16'h0000 || running !== 1'b0)
         $display("FAIL idle_after_reset got %h run=%b want 0000 run=0", digits, running);
      else pass_cnt++;
   endtask

   task automatic test_basic_count();
      do_clear();
      pulse_ss();
      cyc(40);
      total_cnt++;
      if (digits !== 16'h0010) $display("FAIL count_40clk got %h want 0010", digits);
      else pass_cnt++;
      total_cnt++;
      if (running !== 1'b1) $display("FAIL count_running got %b want 1", running);
      else pass_cnt++;
   endtask

   task automatic test_rollover();
      do_clear();
      pulse_ss();
      cyc(DIV * 5999);
      total_cnt++;
      if (digits !== 16'h5999) $display("FAIL to_5999 got %h want 5999", digits);
      else pass_cnt++;
      cyc(DIV - 1);
      total_cnt++;
      if (digits !== 16'h5999 || wrap !== 1'b0)
         $display("FAIL pre_wrap got %h wrap=%b want 5999 wrap=0", digits, wrap);
      else pass_cnt++;
      cyc(1);
      total_cnt++;
      if (digits !== 16'h0000) $display("FAIL wrap_digits got %h want 0000", digits);
      else pass_cnt++;
      total_cnt++;
      if (wrap !== 1'b1 || running !== 1'b1)
         $display("FAIL wrap_pulse got wrap=%b run=%b want 1 1", wrap, running);
      else pass_cnt++;
      cyc(1);
      total_cnt++;
      if (wrap !== 1'b0 || running !== 1'b1)
         $display("FAIL wrap_one_cycle got wrap=%b run=%b want 0 1", wrap, running);
      else pass_cnt++;
      cyc(DIV - 1);
      total_cnt++;
      if (digits !== 16'h0001) $display("FAIL after_wrap got %h want 0001", digits);
      else pass_cnt++;
   endtask

   task automatic test_pause_resume();
      do_clear();
      pulse_ss();            // enter RUN, prescaler 0
      cyc(1);                // prescaler 1
      pulse_ss();            // this edge takes prescaler to 2 and enters PAUSE
      total_cnt++;
      if (running !== 1'b0) $display("FAIL pause_entry got running=%b want 0", running);
      else pass_cnt++;
      cyc(100);
      total_cnt++;
      if (digits !== 16'h0000 || running !== 1'b0)
         $display("FAIL pause_frozen got %h run=%b want 0000 run=0", digits, running);
      else pass_cnt++;
      pulse_ss();            // resume edge, prescaler still 2
      total_cnt++;
      if (digits !== 16'h0000 || running !== 1'b1)
         $display("FAIL resume_edge got %h run=%b want 0000 run=1", digits, running);
      else pass_cnt++;
      cyc(1);
      total_cnt++;
      if (digits !== 16'h0000) $display("FAIL resume_plus1 got %h want 0000", digits);
      else pass_cnt++;
      cyc(1);
      total_cnt++;
      if (digits !== 16'h0001) $display("FAIL resume_plus2 got %h want 0001", digits);
      else pass_cnt++;
   endtask

   task automatic test_clear_priority();
      do_clear();
      pulse_ss();
      cyc(DIV * 1234);
      total_cnt++;
      if (digits !== 16'h1234) $display("FAIL to_1234 got %h want 1234", digits);
      else pass_cnt++;
      clear = 1'b1;
      start_stop = 1'b1;
      cyc(1);
      total_cnt++;
      if (digits !== 16'h0000 || running !== 1'b0 || wrap !== 1'b0)
         $display("FAIL clear_vs_edge got %h run=%b wrap=%b want 0000 0 0",
                  digits, running, wrap);
      else pass_cnt++;
      clear = 1'b0;
      start_stop = 1'b0;
      cyc(8);
      total_cnt++;
      if (digits !== 16'h0000 || running !== 1'b0)
         $display("FAIL clear_stays_idle got %h run=%b want 0000 run=0", digits, running);
      else pass_cnt++;
   endtask

   task automatic test_held_start();
      do_clear();
      start_stop = 1'b1;
      cyc(50);               // RUN for 50 edges -> 12 ticks
      total_cnt++;
      if (running !== 1'b1 || digits !== 16'h0012)
         $display("FAIL held_high got %h run=%b want 0012 run=1", digits, running);
      else pass_cnt++;
      start_stop = 1'b0;
      cyc(1);
      total_cnt++;
      if (running !== 1'b1) $display("FAIL held_release got running=%b want 1", running);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      do_clear();
      pulse_ss();
      cyc(DIV * 357);
      total_cnt++;
      if (digits !== 16'h0357) $display("FAIL to_0357 got %h want 0357", digits);
      else pass_cnt++;
      #2;
      rst_n = 1'b0;
      #1;                    // still mid low-phase, no rising edge yet
      total_cnt++;
      if (digits !== 16'h0000 || running !== 1'b0)
         $display("FAIL async_reset got %h run=%b want 0000 run=0", digits, running);
      else pass_cnt++;
      cyc(1);
      rst_n = 1'b1;
      cyc(20);
      total_cnt++;
      if (digits !== 16'h0000 || running !== 1'b0)
         $display("FAIL post_reset_idle got %h run=%b want 0000 run=0", digits, running);
      else pass_cnt++;
      pulse_ss();
      cyc(DIV);
      total_cnt++;
      if (digits !== 16'h0001 || running !== 1'b1)
         $display("FAIL post_reset_start got %h run=%b want 0001 run=1", digits, running);
      else pass_cnt++;
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      test_reset();
      test_basic_count();
      test_rollover();
      test_pause_resume();
      test_clear_priority();
      test_held_start();
      test_async_reset();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
